// File: rtl/sc_obstacle_generator.sv
// sc_obstacle_generator: LFSR-seeded scrolling obstacle matrix with collision freeze and score.
// Define SC_OBSTACLEGEN_SPEEDUP_EN to shorten the scroll period as the score grows.
module sc_obstacle_generator #(
  parameter int DATAWIDTH = 4,
  parameter int ROWS = 8,
  parameter int TICK_DIV = 50000000,
  parameter int GAP = 2
)(
  input  logic                      SC_ObstacleGen_CLOCK_50,
  input  logic                      SC_ObstacleGen_RESET_InHigh,
  input  logic                      SC_ObstacleGen_Start_InLow,
  input  logic                      SC_ObstacleGen_Collision_InLow,
  output logic [DATAWIDTH-1:0]      SC_ObstacleGen_data_OutBUS,
  output logic [ROWS*DATAWIDTH-1:0] SC_ObstacleGen_Matrix_OutBUS,
  output logic [7:0]                SC_ObstacleGen_Score_OutBUS,
  output logic                      SC_ObstacleGen_Running_Out,
  output logic                      SC_ObstacleGen_Crashed_Out
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  typedef enum logic [1:0] {IDLE, RUN, HIT} stateT;
  stateT state, stateNext;
  logic [15:0] lfsr;
  logic [ROWS*DATAWIDTH-1:0] matrix;
  logic [7:0] score;
  logic [CW-1:0] tickCnt, lastCnt;
  logic [GW-1:0] spawnCnt;
  logic [DATAWIDTH-1:0] pattern, outRow;
  logic restart, tick;
`ifdef SC_OBSTACLEGEN_SPEEDUP_EN
  logic [1:0] level;
  assign level = score[7:4] > 4'd3 ? 2'd3 : score[5:4];
  assign lastCnt = CW'((TICK_DIV >> level) - 1);
`else
  assign lastCnt = CW'(TICK_DIV - 1);
`endif
  assign outRow = matrix[ROWS*DATAWIDTH-1 -: DATAWIDTH];
  // an all-ones pattern would block every lane, so the top lane is cleared
  assign pattern = &lfsr[DATAWIDTH-1:0] ? {1'b0, lfsr[DATAWIDTH-2:0]} : lfsr[DATAWIDTH-1:0];
  always_comb begin
    stateNext = state;
    restart = state != RUN && !SC_ObstacleGen_Start_InLow;
    tick = state == RUN && SC_ObstacleGen_Collision_InLow && tickCnt == lastCnt;
    if (restart) stateNext = RUN;
    else if (state == RUN && !SC_ObstacleGen_Collision_InLow) stateNext = HIT;
  end
  always_ff @(posedge SC_ObstacleGen_CLOCK_50) begin
    if (SC_ObstacleGen_RESET_InHigh) begin
      state <= IDLE;
      lfsr <= 16'hACE1;
      matrix <= '0;
      score <= '0;
      tickCnt <= '0;
      spawnCnt <= '0;
    end else begin
      state <= stateNext;
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (restart) begin
        matrix <= '0;
        score <= '0;
        tickCnt <= '0;
        spawnCnt <= '0;
      end else if (state == RUN && SC_ObstacleGen_Collision_InLow) begin
        tickCnt <= tick ? '0 : tickCnt + CW'(1);
        if (tick) begin
          matrix <= {matrix[(ROWS-1)*DATAWIDTH-1:0], spawnCnt == '0 ? pattern : '0};
          if (|outRow && score != 8'hFF) score <= score + 8'd1;
          spawnCnt <= spawnCnt == GW'(GAP - 1) ? '0 : spawnCnt + GW'(1);
        end
      end
    end
  end
  assign SC_ObstacleGen_data_OutBUS = outRow;
  assign SC_ObstacleGen_Matrix_OutBUS = matrix;
  assign SC_ObstacleGen_Score_OutBUS = score;
  assign SC_ObstacleGen_Running_Out = state == RUN;
  assign SC_ObstacleGen_Crashed_Out = state == HIT;
endmodule

// File: tb/tb_sc_obstacle_generator.sv
// tb_sc_obstacle_generator: directed checks of reset, scrolling, collision freeze, score and free lane.
module tb_sc_obstacle_generator;
  logic clk = 1'b0, rst = 1'b1, startN = 1'b1, collN = 1'b1;
  logic [3:0] data;
  logic [15:0] mat;
  logic [7:0] score;
  logic running, crashed;
  int total = 0, bad = 0;
  logic [15:0] lfM = 16'hACE1;
  logic [15:0] expMat = '0;
  logic [7:0] expScore = '0;
  int spawnCnt = 0;
  logic [3:0] p;
  logic rowF = 1'b0;

  sc_obstacle_generator #(.DATAWIDTH(4), .ROWS(4), .TICK_DIV(16), .GAP(2)) dut (
    .SC_ObstacleGen_CLOCK_50(clk),
    .SC_ObstacleGen_RESET_InHigh(rst),
    .SC_ObstacleGen_Start_InLow(startN),
    .SC_ObstacleGen_Collision_InLow(collN),
    .SC_ObstacleGen_data_OutBUS(data),
    .SC_ObstacleGen_Matrix_OutBUS(mat),
    .SC_ObstacleGen_Score_OutBUS(score),
    .SC_ObstacleGen_Running_Out(running),
    .SC_ObstacleGen_Crashed_Out(crashed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) lfM <= rst ? 16'hACE1 : {lfM[0] ^ lfM[2] ^ lfM[3] ^ lfM[5], lfM[15:1]};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int per();
`ifdef SC_OBSTACLEGEN_SPEEDUP_EN
    return 16 >> (expScore[7:4] > 4'd3 ? 3 : int'(expScore[5:4]));
`else
    return 16;
`endif
  endfunction

  // waits out one scroll period, predicting the spawned row from the LFSR just before the shift
  task automatic tick();
    step(per() - 1);
    p = lfM[3:0] == 4'hF ? 4'h7 : lfM[3:0];
    step(1);
    if (expMat[15:12] != 4'h0 && expScore != 8'hFF) expScore++;
    expMat = {expMat[11:0], spawnCnt == 0 ? p : 4'h0};
    spawnCnt = (spawnCnt + 1) % 2;
    for (int r = 0; r < 4; r++) if (mat[r*4 +: 4] == 4'hF) rowF = 1'b1;
    chk("tick_matrix", mat, expMat);
    chk("tick_data", data, expMat[15:12]);
    chk("tick_score", score, expScore);
  endtask

  task automatic restartRun();
    startN = 1'b0;
    step(1);
    startN = 1'b1;
    expMat = '0;
    expScore = '0;
    spawnCnt = 0;
  endtask

  initial begin
    step(3);
    chk("rst_matrix", mat, 0);
    chk("rst_data", data, 0);
    chk("rst_score", score, 0);
    chk("rst_running", running, 0);
    chk("rst_crashed", crashed, 0);
    rst = 1'b0;
    step(100);
    chk("idle_matrix", mat, 0);
    chk("idle_running", running, 0);
    restartRun();
    chk("start_running", running, 1);
    chk("start_crashed", crashed, 0);
    chk("start_matrix", mat, 0);
    repeat (6) tick();
    step(15);
    collN = 1'b0;
    step(1);
    collN = 1'b1;
    chk("hit_crashed", crashed, 1);
    chk("hit_running", running, 0);
    chk("hit_matrix", mat, expMat);
    chk("hit_score", score, expScore);
    step(200);
    chk("hold_matrix", mat, expMat);
    chk("hold_score", score, expScore);
    chk("hold_crashed", crashed, 1);
    restartRun();
    chk("restart_running", running, 1);
    chk("restart_matrix", mat, 0);
    chk("restart_score", score, 0);
    repeat (1200) tick();
    chk("score_saturated", score, 8'hFF);
    chk("free_lane", rowF, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_matrix", mat, 0);
    chk("midrst_score", score, 0);
    chk("midrst_running", running, 0);
    collN = 1'b0;
    step(5);
    collN = 1'b1;
    chk("idle_coll_crashed", crashed, 0);
    restartRun();
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
